// File: rtl/hazard_ctrl.sv
// hazard_ctrl: WISC decode-stage hazard/forwarding control with X/M shadow scoreboard; HAZARD_PERF_EN adds load-use stall counter
module hazard_ctrl #(
  parameter int REGW = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] srcAD,
  input  logic            srcAValidD,
  input  logic [REGW-1:0] srcBD,
  input  logic            srcBValidD,
  input  logic [REGW-1:0] wrtRegD,
  input  logic            regWrtD,
  input  logic            readEnD,
  input  logic            validD,
  input  logic            createDumpD,
  input  logic            branchTakenX,
  input  logic            memStallM,
  output logic            stallF,
  output logic            bubbleD,
  output logic            flushFD,
  output logic            x2xACntrlD,
  output logic            x2xBCntrlD,
  output logic            m2xACntrlD,
  output logic            m2xBCntrlD,
`ifdef HAZARD_PERF_EN
  output logic            haltedO,
  output logic [CNTW-1:0] stallCountO
`else
  output logic            haltedO
`endif
);
  typedef struct packed {
    logic            valid;
    logic            regWrt;
    logic [REGW-1:0] wrtReg;
    logic            isLoad;
  } sbEntry;
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;
  sbEntry sbX, sbM;
  logic [0:0] state;
  logic frozen, halted, issue, lu;
  logic matchXa, matchXb, matchMa, matchMb;
  always_comb begin
    frozen = memStallM;
    halted = state == HALTED;
    matchXa = srcAValidD & sbX.valid & sbX.regWrt & (sbX.wrtReg == srcAD);
    matchXb = srcBValidD & sbX.valid & sbX.regWrt & (sbX.wrtReg == srcBD);
    matchMa = srcAValidD & sbM.valid & sbM.regWrt & (sbM.wrtReg == srcAD);
    matchMb = srcBValidD & sbM.valid & sbM.regWrt & (sbM.wrtReg == srcBD);
    lu = validD & sbX.isLoad & (matchXa | matchXb);
    x2xACntrlD = validD & matchXa & !sbX.isLoad;
    x2xBCntrlD = validD & matchXb & !sbX.isLoad;
    m2xACntrlD = validD & matchMa & !x2xACntrlD;
    m2xBCntrlD = validD & matchMb & !x2xBCntrlD;
    // a taken branch kills D outright, so it overrides load-use and halt stalls
    stallF = frozen | (!branchTakenX & (lu | halted));
    bubbleD = !frozen & (branchTakenX | lu | halted);
    flushFD = !frozen & branchTakenX;
    issue = validD & !bubbleD & !frozen;
    haltedO = halted;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sbX <= '0;
      sbM <= '0;
      state <= RUN;
    end else if (!frozen) begin
      sbM <= sbX;
      sbX <= issue ? {1'b1, regWrtD, wrtRegD, readEnD} : '0;
      if (issue & createDumpD & !branchTakenX) state <= HALTED;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stallCountO <= '0;
    else if (lu & !frozen & !branchTakenX & ~&stallCountO) stallCountO <= stallCountO + 1'b1;
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven directed bench for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] srcAD, srcBD, wrtRegD;
  logic srcAValidD, srcBValidD, regWrtD, readEnD, validD, createDumpD, branchTakenX, memStallM;
  logic stallF, bubbleD, flushFD, x2xACntrlD, x2xBCntrlD, m2xACntrlD, m2xBCntrlD, haltedO;
`ifdef HAZARD_PERF_EN
  logic [15:0] stallCountO;
`endif
  int errs = 0;
  int checks = 0;

  typedef struct {
    string name;
    logic [2:0] a, b, w;
    logic av, bv, rw, ld, v, dump, br, ms;
    logic [7:0] exp;
  } vec_t;
  vec_t vq[$];

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .srcAD(srcAD), .srcAValidD(srcAValidD), .srcBD(srcBD), .srcBValidD(srcBValidD),
    .wrtRegD(wrtRegD), .regWrtD(regWrtD), .readEnD(readEnD), .validD(validD),
    .createDumpD(createDumpD), .branchTakenX(branchTakenX), .memStallM(memStallM),
    .stallF(stallF), .bubbleD(bubbleD), .flushFD(flushFD),
    .x2xACntrlD(x2xACntrlD), .x2xBCntrlD(x2xBCntrlD),
    .m2xACntrlD(m2xACntrlD), .m2xBCntrlD(m2xBCntrlD),
`ifdef HAZARD_PERF_EN
    .haltedO(haltedO), .stallCountO(stallCountO)
`else
    .haltedO(haltedO)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {stallF, bubbleD, flushFD, x2xACntrlD, x2xBCntrlD, m2xACntrlD, m2xBCntrlD, haltedO};
  endfunction

  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", n, got, exp);
    end
  endtask

  // exp bits: {stallF, bubbleD, flushFD, x2xA, x2xB, m2xA, m2xB, haltedO}
  task automatic add(input string n, input int a, av, b, bv, w, rw, ld, v, dump, br, ms, input logic [7:0] exp);
    vec_t t;
    t.name = n; t.a = 3'(a); t.av = av[0]; t.b = 3'(b); t.bv = bv[0];
    t.w = 3'(w); t.rw = rw[0]; t.ld = ld[0]; t.v = v[0];
    t.dump = dump[0]; t.br = br[0]; t.ms = ms[0]; t.exp = exp;
    vq.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    srcAD = t.a; srcAValidD = t.av; srcBD = t.b; srcBValidD = t.bv;
    wrtRegD = t.w; regWrtD = t.rw; readEnD = t.ld; validD = t.v;
    createDumpD = t.dump; branchTakenX = t.br; memStallM = t.ms;
  endtask

  initial begin
    vec_t t;
    //      name          a av b bv w rw ld v dp br ms  expected
    add("idle",           0,0, 0,0, 0,0,0, 0,0, 0,0, 8'b0000_0000);
    add("add_r3",         0,0, 0,0, 3,1,0, 1,0, 0,0, 8'b0000_0000);
    add("x2xA_r3",        3,1, 0,0, 4,0,0, 1,0, 0,0, 8'b0001_0000);
    add("m2xB_r3",        0,0, 3,1, 0,0,0, 1,0, 0,0, 8'b0000_0010);
    add("wr_r5",          0,0, 0,0, 5,1,0, 1,0, 0,0, 8'b0000_0000);
    add("wr_r5_again",    5,1, 0,0, 5,1,0, 1,0, 0,0, 8'b0001_0000);
    add("x_over_m_B",     0,0, 5,1, 0,0,0, 1,0, 0,0, 8'b0000_1000);
    add("m2xB_r5",        0,0, 5,1, 0,0,0, 1,0, 0,0, 8'b0000_0010);
    add("r1_first",       1,1, 1,1, 1,1,0, 1,0, 0,0, 8'b0000_0000);
    add("r1_r1_r1",       1,1, 1,1, 1,1,0, 1,0, 0,0, 8'b0001_1000);
    add("ld_r2",          0,0, 0,0, 2,1,1, 1,0, 0,0, 8'b0000_0000);
    add("lu_A",           2,1, 0,0, 6,1,0, 1,0, 0,0, 8'b1100_0000);
    add("lu_A_m2x",       2,1, 0,0, 6,1,0, 1,0, 0,0, 8'b0000_0100);
    add("ld_r2_b",        0,0, 0,0, 2,1,1, 1,0, 0,0, 8'b0000_0000);
    add("lu_AB",          2,1, 2,1, 0,0,0, 1,0, 0,0, 8'b1100_0000);
    add("lu_AB_m2x",      2,1, 2,1, 0,0,0, 1,0, 0,0, 8'b0000_0110);
    add("ld_r2_c",        0,0, 0,0, 2,1,1, 1,0, 0,0, 8'b0000_0000);
    add("br_over_lu",     2,1, 0,0, 0,0,0, 1,0, 1,0, 8'b0110_0000);
    add("after_br",       2,1, 0,0, 0,0,0, 1,0, 0,0, 8'b0000_0100);
    add("wr_r7",          0,0, 0,0, 7,1,0, 1,0, 0,0, 8'b0000_0000);
    add("frz1",           7,1, 0,0, 0,0,0, 1,0, 0,1, 8'b1001_0000);
    add("frz2",           7,1, 0,0, 0,0,0, 1,0, 0,1, 8'b1001_0000);
    add("frz3",           7,1, 0,0, 0,0,0, 1,0, 0,1, 8'b1001_0000);
    add("frz_release",    7,1, 0,0, 0,0,0, 1,0, 0,0, 8'b0001_0000);
    add("frz_adv1",       7,1, 0,0, 0,0,0, 1,0, 0,0, 8'b0000_0100);
    add("frz_adv2",       7,1, 0,0, 0,0,0, 1,0, 0,0, 8'b0000_0000);
    add("ld_r4",          0,0, 0,0, 4,1,1, 1,0, 0,0, 8'b0000_0000);
    add("frz_br",         4,1, 0,0, 0,0,0, 1,0, 1,1, 8'b1000_0000);
    add("br_after_frz",   4,1, 0,0, 0,0,0, 1,0, 1,0, 8'b0110_0000);
    add("halt_with_br",   0,0, 0,0, 0,0,0, 1,1, 1,0, 8'b0110_0000);
    add("no_halt",        0,0, 0,0, 0,0,0, 0,0, 0,0, 8'b0000_0000);
    add("wr_r3_pre",      0,0, 0,0, 3,1,0, 1,0, 0,0, 8'b0000_0000);
    add("halt_issue",     0,0, 0,0, 0,0,0, 1,1, 0,0, 8'b0000_0000);
    add("halted",         0,0, 0,0, 0,0,0, 1,0, 0,0, 8'b1100_0001);
    add("halted_frz",     0,0, 0,0, 0,0,0, 1,0, 0,1, 8'b1000_0001);

    apply(vq[1]);
    #12;
    chk("reset_outs", 16'(outs()), 16'h0000);
`ifdef HAZARD_PERF_EN
    chk("reset_cnt", stallCountO, 16'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i]);
      #1;
      chk(vq[i].name, 16'(outs()), 16'(vq[i].exp));
      @(negedge clk);
    end
`ifdef HAZARD_PERF_EN
    chk("lu_count", stallCountO, 16'd2);
`endif
    t = vq[33];
    for (int i = 0; i < 12; i++) begin
      apply(t);
      #1;
      chk("halt_hold", 16'(outs()), 16'b1100_0001);
      @(negedge clk);
    end
    t.a = 3'd3; t.av = 1'b1; t.dump = 1'b1;
    apply(t);
    #2 rst = 1'b0;
    #1 chk("rst_mid_halt", 16'(outs()), 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    apply(vq[0]);
    #1 chk("post_rst_run", 16'(outs()), 16'h0000);
    @(negedge clk);
    apply(vq[10]);
    #1 chk("ld_r2_post", 16'(outs()), 16'h0000);
    @(negedge clk);
    apply(vq[11]);
    #1 chk("lu_pre_rst", 16'(outs()), 16'b1100_0000);
    #2 rst = 1'b0;
    #1 chk("rst_mid_stall", 16'(outs()), 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post_rst_empty", 16'(outs()), 16'h0000);
`ifdef HAZARD_PERF_EN
    chk("post_rst_cnt", stallCountO, 16'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Decode-stage hazard and forwarding controller for the 5-stage WISC pipeline. Sits directly upstream of the decode/execute pipeline register and produces the per-instruction forwarding selects (`x2x*CntrlD`, `m2x*CntrlD`) that register captures. It also produces the stall, bubble and flush controls for fetch/decode. It keeps its own shadow scoreboard of the instructions occupying the X and M stages, so it needs no taps from downstream pipeline registers.

## Interface
Parameters:
- `REGW`, default 3: register-specifier width (8 GPRs).
- `CNTW`, default 16: stall-counter width (used only with `HAZARD_PERF_EN`).

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `srcAD` in REGW: decode-stage source A register.
- `srcAValidD` in 1: instruction in D reads `srcAD`.
- `srcBD` in REGW: decode-stage source B register.
- `srcBValidD` in 1: instruction in D reads `srcBD`.
- `wrtRegD` in REGW: destination register of the instruction in D.
- `regWrtD` in 1: instruction in D writes `wrtRegD`.
- `readEnD` in 1: instruction in D is a load.
- `validD` in 1: D holds a real instruction (0 = NOP/bubble).
- `createDumpD` in 1: instruction in D is HALT.
- `branchTakenX` in 1: the instruction in X redirects the PC.
- `memStallM` in 1: data memory busy; the whole pipeline freezes.
- `stallF` out 1: hold PC and the F/D register.
- `bubbleD` out 1: load NOP controls into the D/X register this cycle.
- `flushFD` out 1: kill the F/D register contents this cycle.
- `x2xACntrlD`, `x2xBCntrlD` out 1 each: forward the X-stage ALU result to operand A/B.
- `m2xACntrlD`, `m2xBCntrlD` out 1 each: forward the M-stage result (ALU or load data) to operand A/B.
- `haltedO` out 1: HALT has issued; fetch is stopped.
- `stallCountO` out CNTW: load-use stall cycles (present only with `HAZARD_PERF_EN`).

## Operation
- Scoreboard: two entries, `sbX` and `sbM`. Each entry holds {valid, regWrt, wrtReg, isLoad}.
- Per-cycle scoreboard update (when not frozen): `sbM <= sbX`; `sbX <= issue ? {1, regWrtD, wrtRegD, readEnD} : 0`.
- `issue = validD & !bubbleD & !frozen`. `frozen = memStallM`.
- Match rules:
  - `matchXa = srcAValidD & sbX.valid & sbX.regWrt & (sbX.wrtReg == srcAD)`; B and the M-stage matches are analogous.
- Load-use hazard: `lu = validD & sbX.isLoad & (matchXa | matchXb)`.
- Forwarding selects:
  - `x2xA = matchXa & !sbX.isLoad`.
  - `m2xA = matchMa & !x2xA`. X has priority over M.
  - B is analogous.
  - All forwarding selects are 0 when `!validD`.
- Control priority, highest first:
  1. `frozen`: `stallF=1`, `bubbleD=0`, `flushFD=0`, scoreboard held.
  2. `branchTakenX`: `flushFD=1`, `bubbleD=1` (D is killed), `stallF=0`; any HALT or load-use in D is discarded.
  3. `lu`: `stallF=1`, `bubbleD=1`. Exactly one cycle, because the next cycle the load is in `sbM` and is served by m2x.
  4. Otherwise: all three controls are 0.
- Halt FSM, states RUN and HALTED:
  - RUN→HALTED on `issue & createDumpD & !branchTakenX`.
  - In HALTED: `stallF=1` and `bubbleD=1` (unless frozen); `haltedO=1`.
  - Only reset leaves HALTED.
  - The scoreboard keeps draining while HALTED, so in-flight writers complete.

## Timing
- Forwarding, stall, bubble and flush outputs are combinational from the D inputs and registered state, valid in the same cycle. The D/X register captures them at the next edge.
- The scoreboard and halt state update on the rising `clk` edge.
- Asynchronous reset (`rst=0`), effective immediately:
  - `sbX` and `sbM` invalid, FSM = RUN, `stallCountO=0`.
  - Resulting outputs: `stallF=0`, `bubbleD=0`, `flushFD=0`, all forwarding selects 0, `haltedO=0`.
- Reset asserted mid-stall or while HALTED clears everything; the first post-reset cycle sees an empty scoreboard.
- Simultaneous `memStallM` and `branchTakenX`: the flush is deferred until `memStallM` deasserts. The X stage is frozen, so `branchTakenX` stays held until then.
- Simultaneous load-use on both A and B: still a single-cycle stall.
- Destination equal to source (e.g. `ADD r1,r1,r1` back-to-back): a normal match; no special case.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stallCountO` exists.
  - Increments by 1 on each cycle where `lu & !frozen & !branchTakenX`.
  - Saturates at all-ones; no wrap.
  - Reset value 0.
- `HAZARD_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- ALU-to-ALU: `ADD r3←` issued, then next cycle D reads r3 on A → `x2xACntrlD=1`, `m2xACntrlD=0`, no stall.
- Two-back: writer of r5, one unrelated instruction, then D reads r5 on B → `m2xBCntrlD=1`. If the middle instruction also writes r5 → `x2xBCntrlD=1`, `m2xBCntrlD=0`.
- Load-use: `LD r2` then D reads r2 on A → one cycle of `stallF=1`, `bubbleD=1`. Next cycle `m2xACntrlD=1`, no stall. With `HAZARD_PERF_EN`, `stallCountO` goes 0→1.
- Branch flush over a hazard: `branchTakenX=1` while D has a load-use on r2 → `flushFD=1`, `bubbleD=1`, `stallF=0`; counter unchanged; next-cycle `sbX` invalid.
- Freeze: `memStallM=1` for 3 cycles with a matching writer in X → `stallF=1` and `bubbleD=0` throughout. Forwarding selects stay stable. After release the scoreboard advances exactly one stage per cycle.
- Halt and reset: HALT issued → `haltedO=1` next cycle, `stallF=1` persists for 10+ cycles. Asserting `rst=0` mid-HALT → all outputs 0 immediately. A HALT issued together with `branchTakenX` never sets `haltedO`.
